// File: rtl/exe_stream.sv
// exe_stream: execute stage of an in-order pipeline with a valid/allowin
// handshake on both sides.
//
// Optional feature macro: EXE_DIV_EN. When defined, ops C-F (the signed and
// unsigned divide and remainder operations) run on a 32-cycle radix-2
// restoring divider and the stage stalls until the result is ready. When
// undefined, ops C-F return 0 and the stage never stalls on its own.
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   ID_to_EXE_valid          ID offers an instruction
//   MEM_allowin              MEM can accept this cycle
//   EXE_*_in                 instruction fields captured into the stage buffer
//   EXE_allowin              EXE can accept from ID
//   EXE_to_MEM_valid         result offered to MEM
//   EXE_pc_out .. EXE_rf_waddr_out   buffered fields / ALU result
//   data_sram_en/we/addr/wdata       data SRAM request, issued in the cycle
//                                    the instruction hands off to MEM
module exe_stream (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_to_EXE_valid,
  input  logic        MEM_allowin,
  input  logic [31:0] EXE_pc_in,
  input  logic [3:0]  EXE_alu_op_in,
  input  logic [31:0] EXE_alu_src1_in,
  input  logic [31:0] EXE_alu_src2_in,
  input  logic [3:0]  EXE_mem_ctrl_in,
  input  logic [31:0] EXE_st_data_in,
  input  logic        EXE_rf_we_in,
  input  logic [4:0]  EXE_rf_waddr_in,
  output logic        EXE_allowin,
  output logic        EXE_to_MEM_valid,
  output logic [31:0] EXE_pc_out,
  output logic [31:0] EXE_alu_res_out,
  output logic        EXE_res_from_mem_out,
  output logic        EXE_rf_we_out,
  output logic [4:0]  EXE_rf_waddr_out,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  // Stage buffer
  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [3:0]  op_reg;
  logic [31:0] src1_reg;
  logic [31:0] src2_reg;
  logic [3:0]  mem_ctrl_reg;
  logic [31:0] st_data_reg;
  logic        rf_we_reg;
  logic [4:0]  rf_waddr_reg;

  logic        ready_go;
  logic [31:0] alu_res;
  logic [31:0] div_res;
  logic        is_div;

  assign is_div           = (op_reg[3:2] == 2'b11);
  assign EXE_allowin      = !valid_reg || (ready_go && MEM_allowin);
  assign EXE_to_MEM_valid = valid_reg && ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_reg    <= 1'b0;
      pc_reg       <= 32'd0;
      op_reg       <= 4'd0;
      src1_reg     <= 32'd0;
      src2_reg     <= 32'd0;
      mem_ctrl_reg <= 4'd0;
      st_data_reg  <= 32'd0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= 5'd0;
    end else begin
      if (EXE_allowin) begin
        valid_reg <= ID_to_EXE_valid;
      end
      if (ID_to_EXE_valid && EXE_allowin) begin
        pc_reg       <= EXE_pc_in;
        op_reg       <= EXE_alu_op_in;
        src1_reg     <= EXE_alu_src1_in;
        src2_reg     <= EXE_alu_src2_in;
        mem_ctrl_reg <= EXE_mem_ctrl_in;
        st_data_reg  <= EXE_st_data_in;
        rf_we_reg    <= EXE_rf_we_in;
        rf_waddr_reg <= EXE_rf_waddr_in;
      end
    end
  end

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  div_state_t  state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] quo_reg, quo_next;    // dividend shifts out as quotient shifts in
  logic [31:0] rem_reg, rem_next;
  logic [31:0] dsor_reg, dsor_next;

  logic        div_signed;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // C and E are the signed variants (op[0] clear)
  assign div_signed = !op_reg[0];
  assign src1_neg   = div_signed && src1_reg[31];
  assign src2_neg   = div_signed && src2_reg[31];
  assign mag1       = src1_neg ? -src1_reg : src1_reg;
  assign mag2       = src2_neg ? -src2_reg : src2_reg;
  assign trial      = {rem_reg, quo_reg[31]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= DIV_IDLE;
      count_reg <= 5'd0;
      quo_reg   <= 32'd0;
      rem_reg   <= 32'd0;
      dsor_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dsor_reg  <= dsor_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dsor_next  = dsor_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (valid_reg && is_div) begin
          state_next = DIV_BUSY;
          count_next = 5'd0;
          quo_next   = mag1;
          rem_next   = 32'd0;
          dsor_next  = mag2;
        end
      end
      DIV_BUSY: begin
        // 33-bit compare: a zero divisor makes the partial remainder simply
        // accumulate the dividend, which is fixed up at the output anyway.
        if (trial >= {1'b0, dsor_reg}) begin
          rem_next = trial[31:0] - dsor_reg;
          quo_next = {quo_reg[30:0], 1'b1};
        end else begin
          rem_next = trial[31:0];
          quo_next = {quo_reg[30:0], 1'b0};
        end
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd31) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // Leaves only when MEM takes the result, so a stalled result is never
        // recomputed for the same instruction.
        if (MEM_allowin) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Most-negative / -1 needs no special case: the magnitude 0x80000000
  // negates to itself and the remainder is 0.
  assign quo_fix  = (src1_neg ^ src2_neg) ? -quo_reg : quo_reg;
  assign rem_fix  = src1_neg ? -rem_reg : rem_reg;
  assign div_res  = (src2_reg == 32'd0) ? (op_reg[1] ? src1_reg : 32'hFFFF_FFFF)
                                        : (op_reg[1] ? rem_fix : quo_fix);
  assign ready_go = !is_div || (state_reg == DIV_DONE);
`else
  assign div_res  = 32'd0;
  assign ready_go = 1'b1;
`endif

  always_comb begin
    alu_res = 32'd0;
    case (op_reg)
      4'h0: alu_res = src1_reg + src2_reg;
      4'h1: alu_res = src1_reg - src2_reg;
      4'h2: alu_res = {31'd0, $signed(src1_reg) < $signed(src2_reg)};
      4'h3: alu_res = {31'd0, src1_reg < src2_reg};
      4'h4: alu_res = src1_reg & src2_reg;
      4'h5: alu_res = src1_reg | src2_reg;
      4'h6: alu_res = src1_reg ^ src2_reg;
      4'h7: alu_res = ~(src1_reg | src2_reg);
      4'h8: alu_res = src1_reg << src2_reg[4:0];
      4'h9: alu_res = src1_reg >> src2_reg[4:0];
      4'hA: alu_res = $unsigned($signed(src1_reg) >>> src2_reg[4:0]);
      4'hB: alu_res = src2_reg;
      default: alu_res = div_res;
    endcase
  end

  assign EXE_pc_out           = pc_reg;
  assign EXE_alu_res_out      = alu_res;
  assign EXE_res_from_mem_out = mem_ctrl_reg[2];
  assign EXE_rf_we_out        = rf_we_reg && valid_reg;
  assign EXE_rf_waddr_out     = rf_waddr_reg;

  // The SRAM request goes out in the handoff cycle so load data is returned
  // while the instruction sits in MEM.
  assign data_sram_en   = valid_reg && ready_go && MEM_allowin &&
                          (mem_ctrl_reg[3] || mem_ctrl_reg[2]);
  assign data_sram_addr = alu_res;

  // Low address bits are not checked for alignment: word ignores [1:0],
  // half ignores [0].
  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = st_data_reg;
    case (mem_ctrl_reg[1:0])
      2'd0: begin
        data_sram_wdata = {4{st_data_reg[7:0]}};
        if (data_sram_en && mem_ctrl_reg[3]) data_sram_we = 4'b0001 << alu_res[1:0];
      end
      2'd1: begin
        data_sram_wdata = {2{st_data_reg[15:0]}};
        if (data_sram_en && mem_ctrl_reg[3]) data_sram_we = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (data_sram_en && mem_ctrl_reg[3]) data_sram_we = 4'b1111;
      end
    endcase
  end

endmodule

// File: tb/tb_exe_stream.sv
// Testbench for exe_stream: directed vectors with literal expectations plus a
// queue-based reference model checked every cycle by one compare process.
// Honours EXE_DIV_EN the same way the design does.
module tb_exe_stream;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ID_to_EXE_valid;
  logic        MEM_allowin;
  logic [31:0] EXE_pc_in;
  logic [3:0]  EXE_alu_op_in;
  logic [31:0] EXE_alu_src1_in;
  logic [31:0] EXE_alu_src2_in;
  logic [3:0]  EXE_mem_ctrl_in;
  logic [31:0] EXE_st_data_in;
  logic        EXE_rf_we_in;
  logic [4:0]  EXE_rf_waddr_in;
  logic        EXE_allowin;
  logic        EXE_to_MEM_valid;
  logic [31:0] EXE_pc_out;
  logic [31:0] EXE_alu_res_out;
  logic        EXE_res_from_mem_out;
  logic        EXE_rf_we_out;
  logic [4:0]  EXE_rf_waddr_out;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  always #5 clk = ~clk;

  exe_stream dut (
    .clk(clk), .resetn(resetn),
    .ID_to_EXE_valid(ID_to_EXE_valid), .MEM_allowin(MEM_allowin),
    .EXE_pc_in(EXE_pc_in), .EXE_alu_op_in(EXE_alu_op_in),
    .EXE_alu_src1_in(EXE_alu_src1_in), .EXE_alu_src2_in(EXE_alu_src2_in),
    .EXE_mem_ctrl_in(EXE_mem_ctrl_in), .EXE_st_data_in(EXE_st_data_in),
    .EXE_rf_we_in(EXE_rf_we_in), .EXE_rf_waddr_in(EXE_rf_waddr_in),
    .EXE_allowin(EXE_allowin), .EXE_to_MEM_valid(EXE_to_MEM_valid),
    .EXE_pc_out(EXE_pc_out), .EXE_alu_res_out(EXE_alu_res_out),
    .EXE_res_from_mem_out(EXE_res_from_mem_out), .EXE_rf_we_out(EXE_rf_we_out),
    .EXE_rf_waddr_out(EXE_rf_waddr_out), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

`ifdef EXE_DIV_EN
  localparam int DIV_LAT = 33;
`else
  localparam int DIV_LAT = 0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mem;
    logic [31:0] st;
    logic        we;
    logic [4:0]  wa;
    int          k;    // first cycle the instruction sits in EXE
    int          rdy;  // first cycle its result may be offered to MEM
  } txn_t;

  txn_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  bit          checking = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  // Reference results straight from the operation definitions.
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return (sa < sb) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~(a | b);
      4'h8: return a << b[4:0];
      4'h9: return a >> b[4:0];
      4'hA: return $unsigned(sa >>> b[4:0]);
      4'hB: return b;
      default: begin
`ifdef EXE_DIV_EN
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        return op[1] ? $unsigned(sa % sb) : $unsigned(sa / sb);
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, 2 time units after the falling edge.
  initial begin
    txn_t        t;
    logic        occ;
    logic        vld;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] res;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      cyc++;
      #2;
      if (checking) begin
        t = '{default: 0};
        if (q.size() > 0) t = q[0];
        occ    = (q.size() > 0) && (cyc >= t.k);
        vld    = occ && (cyc >= t.rdy);
        exp_en = vld && MEM_allowin && (t.mem[3] || t.mem[2]);
        res    = model_alu(t.op, t.a, t.b);
        exp_we = 4'b0000;
        wd     = t.st;
        case (t.mem[1:0])
          2'd0: begin wd = {4{t.st[7:0]}};  if (exp_en && t.mem[3]) exp_we = 4'b0001 << res[1:0]; end
          2'd1: begin wd = {2{t.st[15:0]}}; if (exp_en && t.mem[3]) exp_we = res[1] ? 4'b1100 : 4'b0011; end
          default: if (exp_en && t.mem[3]) exp_we = 4'b1111;
        endcase
        chk("to_mem_valid", 32'(EXE_to_MEM_valid), 32'(vld));
        chk("allowin", 32'(EXE_allowin), 32'(!occ || (vld && MEM_allowin)));
        chk("rf_we_out", 32'(EXE_rf_we_out), 32'(occ && t.we));
        chk("sram_en", 32'(data_sram_en), 32'(exp_en));
        chk("sram_we", 32'(data_sram_we), 32'(exp_we));
        if (vld) begin
          chk("pc", EXE_pc_out, t.pc);
          chk("alu_res", EXE_alu_res_out, res);
          chk("sram_addr", data_sram_addr, res);
          chk("res_from_mem", 32'(EXE_res_from_mem_out), 32'(t.mem[2]));
          chk("rf_waddr", 32'(EXE_rf_waddr_out), 32'(t.wa));
        end
        if (exp_en && t.mem[3]) chk("sram_wdata", data_sram_wdata, wd);
        if (!resetn) q.delete();
        else if (vld && MEM_allowin) void'(q.pop_front());
      end
    end
  end

  // Offer one instruction; returns after the accepting edge with valid dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] mem, input logic [31:0] st, input logic we,
                       input logic [4:0] wa);
    txn_t t;
    int   waited;
    waited = 0;
    @(negedge clk);
    EXE_pc_in       = pc_ctr;
    EXE_alu_op_in   = op;
    EXE_alu_src1_in = a;
    EXE_alu_src2_in = b;
    EXE_mem_ctrl_in = mem;
    EXE_st_data_in  = st;
    EXE_rf_we_in    = we;
    EXE_rf_waddr_in = wa;
    ID_to_EXE_valid = 1'b1;
    #1;
    while (!EXE_allowin) begin
      if (waited == 100) begin
        compared++;
        mismatched++;
        $display("FAIL issue_timeout: allowin got 0 for 100 cycles, expected 1");
        ID_to_EXE_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    t.pc  = pc_ctr;
    t.op  = op;
    t.a   = a;
    t.b   = b;
    t.mem = mem;
    t.st  = st;
    t.we  = we;
    t.wa  = wa;
    t.k   = cyc + 1;
    t.rdy = t.k + ((op[3:2] == 2'b11) ? DIV_LAT : 0);
    q.push_back(t);
    $display("issue op=%h a=%h b=%h mem=%b pc=%h cycle=%0d", op, a, b, mem, pc_ctr, cyc);
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    #1;
    ID_to_EXE_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    step();
    while (!EXE_to_MEM_valid && n < max_cycles) begin
      step();
      n++;
    end
    if (!EXE_to_MEM_valid) begin
      compared++;
      mismatched++;
      $display("FAIL wait_valid: to_mem_valid got 0 after %0d cycles, expected 1", max_cycles);
    end
  endtask

  logic [3:0]  tab_op  [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [31:0] tab_a   [11] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                32'hFFFF_0000, 32'hF0F0_F0F0, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'd0};
  logic [31:0] tab_b   [11] = '{32'd7, 32'd1, 32'd1, 32'hFF00_FF00, 32'h0F0F_0000,
                                32'h0F0F_0F0F, 32'h0F0F_0000, 32'd35, 32'd4, 32'd4, 32'h1234_5000};
  logic [31:0] tab_exp [11] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF000_F000, 32'hFFFF_F0F0,
                                32'hF0F0_0F0F, 32'h0000_0F0F, 32'd8, 32'h0800_0000, 32'hF800_0000,
                                32'h1234_5000};

  initial begin
    int n;
`ifdef EXE_DIV_EN
    logic [31:0] exp_div  = 32'hFFFF_FFFD;
    logic [31:0] exp_mod  = 32'hFFFF_FFFF;
    logic [31:0] exp_divu = 32'hFFFF_FFFF;
`else
    logic [31:0] exp_div  = 32'd0;
    logic [31:0] exp_mod  = 32'd0;
    logic [31:0] exp_divu = 32'd0;
`endif
    resetn          = 1'b0;
    MEM_allowin     = 1'b1;
    ID_to_EXE_valid = 1'b0;
    EXE_pc_in       = 32'd0;
    EXE_alu_op_in   = 4'd0;
    EXE_alu_src1_in = 32'd0;
    EXE_alu_src2_in = 32'd0;
    EXE_mem_ctrl_in = 4'd0;
    EXE_st_data_in  = 32'd0;
    EXE_rf_we_in    = 1'b0;
    EXE_rf_waddr_in = 5'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #3;
    chk("reset_allowin", 32'(EXE_allowin), 32'd1);
    chk("reset_valid", 32'(EXE_to_MEM_valid), 32'd0);
    chk("reset_sram_en", 32'(data_sram_en), 32'd0);
    chk("reset_sram_we", 32'(data_sram_we), 32'd0);
    chk("reset_rf_we", 32'(EXE_rf_we_out), 32'd0);
    checking = 1'b1;

    // ADD 5 + 7
    issue(4'h0, 32'd5, 32'd7, 4'b0000, 32'd0, 1'b1, 5'd3);
    step();
    chk("add_valid", 32'(EXE_to_MEM_valid), 32'd1);
    chk("add_res", EXE_alu_res_out, 32'd12);
    chk("add_sram_en", 32'(data_sram_en), 32'd0);

    for (int i = 0; i < 11; i++) begin
      issue(tab_op[i], tab_a[i], tab_b[i], 4'b0000, 32'd0, i[0], 5'(i + 1));
      step();
      chk("alu_table", EXE_alu_res_out, tab_exp[i]);
    end

    // Byte store to 0x1003
    issue(4'h0, 32'h0000_1000, 32'd3, 4'b1000, 32'h0000_00AB, 1'b0, 5'd0);
    step();
    chk("sb_en", 32'(data_sram_en), 32'd1);
    chk("sb_we", 32'(data_sram_we), 32'b1000);
    chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    step();
    chk("sb_en_once", 32'(data_sram_en), 32'd0);

    // Half / word stores and a load held by MEM for two cycles
    issue(4'h0, 32'h0000_2000, 32'd2, 4'b1001, 32'h1234_ABCD, 1'b0, 5'd0);
    issue(4'h0, 32'h0000_3000, 32'd1, 4'b1010, 32'hDEAD_BEEF, 1'b0, 5'd0);
    issue(4'h0, 32'h0000_4000, 32'd4, 4'b0110, 32'd0, 1'b1, 5'd9);
    @(negedge clk);
    MEM_allowin = 1'b0;
    repeat (2) @(negedge clk);
    MEM_allowin = 1'b1;
    step();

    // Signed divide and modulo of -7 by 2
    issue(4'hC, 32'hFFFF_FFF9, 32'd2, 4'b0000, 32'd0, 1'b1, 5'd4);
`ifdef EXE_DIV_EN
    for (int i = 0; i < 33; i++) begin
      step();
      chk("div_busy_allowin", 32'(EXE_allowin), 32'd0);
    end
    step();
`else
    step();
`endif
    chk("div_valid", 32'(EXE_to_MEM_valid), 32'd1);
    chk("div_res", EXE_alu_res_out, exp_div);
    issue(4'hE, 32'hFFFF_FFF9, 32'd2, 4'b0000, 32'd0, 1'b1, 5'd5);
    wait_valid(40);
    chk("mod_res", EXE_alu_res_out, exp_mod);

    // DIVU 9 / 0 with MEM stalled for 5 cycles
    step();
    MEM_allowin = 1'b0;
    issue(4'hD, 32'd9, 32'd0, 4'b0000, 32'd0, 1'b1, 5'd6);
    wait_valid(40);
    chk("divu0_res", EXE_alu_res_out, exp_divu);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("divu0_hold_valid", 32'(EXE_to_MEM_valid), 32'd1);
      chk("divu0_hold_res", EXE_alu_res_out, exp_divu);
    end
    @(negedge clk);
    MEM_allowin = 1'b1;

    // Corner divides checked through the model only
    issue(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b1, 5'd7);
    issue(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b1, 5'd8);
    issue(4'hC, 32'hFFFF_FFF9, 32'd0, 4'b0000, 32'd0, 1'b1, 5'd9);
    issue(4'hE, 32'hFFFF_FFF9, 32'd0, 4'b0000, 32'd0, 1'b1, 5'd10);
    issue(4'hF, 32'd100, 32'd7, 4'b0000, 32'd0, 1'b1, 5'd11);
    issue(4'hE, 32'd7, 32'hFFFF_FFFE, 4'b0000, 32'd0, 1'b1, 5'd12);

    // Reset in the middle of a division, then a normal ADD
    issue(4'hC, 32'd1000, 32'd7, 4'b0000, 32'd0, 1'b1, 5'd13);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #3;
    chk("rst_div_valid", 32'(EXE_to_MEM_valid), 32'd0);
    chk("rst_div_allowin", 32'(EXE_allowin), 32'd1);
    issue(4'h0, 32'd20, 32'd22, 4'b0000, 32'd0, 1'b1, 5'd14);
    step();
    chk("post_rst_valid", 32'(EXE_to_MEM_valid), 32'd1);
    chk("post_rst_add", EXE_alu_res_out, 32'd42);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_stream.md
EXE_STREAM -- requirements
Module: exe_stream

Interface
REQ-001 SHALL have clock and reset: one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-004 SHALL have port ID_to_EXE_valid  in  1  ID offers an instruction.
REQ-005 SHALL have port MEM_allowin  in  1  MEM can accept this cycle.
REQ-006 SHALL have port EXE_pc_in  in  32  instruction PC.
REQ-007 SHALL have port EXE_alu_op_in  in  4  operation code (0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, A SRA, B LUI, C DIV, D DIVU, E MOD, F MODU).
REQ-008 SHALL have port EXE_alu_src1_in  in  32  operand 1.
REQ-009 SHALL have port EXE_alu_src2_in  in  32  operand 2.
REQ-010 SHALL have port EXE_mem_ctrl_in  in  4  {store, load, size[1:0]}; size 0 byte, 1 half, 2 word.
REQ-011 SHALL have port EXE_st_data_in  in  32  store data.
REQ-012 SHALL have port EXE_rf_we_in  in  1  register write enable.
REQ-013 SHALL have port EXE_rf_waddr_in  in  5  destination register.
REQ-014 SHALL have port EXE_allowin  out  1  EXE can accept from ID.
REQ-015 SHALL have port EXE_to_MEM_valid  out  1  result offered to MEM.
REQ-016 SHALL have port EXE_pc_out  out  32  buffered PC.
REQ-017 SHALL have port EXE_alu_res_out  out  32  operation result / memory address.
REQ-018 SHALL have port EXE_res_from_mem_out  out  1  buffered load flag.
REQ-019 SHALL have port EXE_rf_we_out  out  1  rf_we gated by EXE valid.
REQ-020 SHALL have port EXE_rf_waddr_out  out  5  buffered destination.
REQ-021 SHALL have port data_sram_en  out  1  data SRAM access request.
REQ-022 SHALL have port data_sram_we  out  4  byte write strobes.
REQ-023 SHALL have port data_sram_addr  out  32  equals EXE_alu_res_out.
REQ-024 SHALL have port data_sram_wdata  out  32  replicated store data.

Function
REQ-025 SHALL capture all *_in fields into the stage buffer on a clock edge where ID_to_EXE_valid && EXE_allowin; otherwise the buffer holds.
REQ-026 SHALL update EXE_valid with ID_to_EXE_valid on every edge where EXE_allowin is 1.
REQ-027 SHALL drive EXE_allowin = !EXE_valid || (EXE_ready_go && MEM_allowin) and EXE_to_MEM_valid = EXE_valid && EXE_ready_go.
REQ-028 SHALL compute ops 0-B combinationally from buffered operands; shifts use src2[4:0]; LUI returns src2; SLT is signed, SLTU unsigned; comparisons return 0 or 1.
REQ-029 SHALL assert data_sram_en only when EXE_valid && EXE_ready_go && MEM_allowin && (store || load), so load data arrives in MEM on the next cycle.
REQ-030 SHALL drive data_sram_we = 0 unless data_sram_en && store; under that condition byte: 4'b0001<<addr[1:0] with wdata {4{st[7:0]}}; half: addr[1] ? 4'b1100 : 4'b0011 with wdata {2{st[15:0]}}; word: 4'b1111 with wdata st.
REQ-031 SHALL ignore addr[1:0] for word and addr[0] for half; it performs no misalignment check.
REQ-032 SHALL hold EXE_ready_go at 1 for ops 0-B and SHALL derive it for ops C-F from the divider state machine.
REQ-033 SHALL implement divider states IDLE, BUSY, DONE: IDLE->BUSY when EXE_valid && divide op, loading count=0 and magnitudes; BUSY produces one quotient bit per cycle, ->DONE after 32 cycles; DONE->IDLE on an edge where MEM_allowin is 1.
REQ-034 SHALL assert ready_go only in DONE for a divide op entering at cycle 0, giving EXE_to_MEM_valid at cycle 33 at the earliest.
REQ-035 SHALL hold the DONE result stably while MEM_allowin=0 and SHALL not restart the divider for the same instruction.
REQ-036 SHALL return signed quotient negative iff operand signs differ, and signed remainder with the sign of src1.
REQ-037 SHALL, on divisor 0, return quotient 32'hFFFFFFFF and remainder src1; on 32'h80000000 / -1 signed, return quotient 32'h80000000 and remainder 0.

Reset
REQ-038 SHALL, when resetn=0 at a clock edge, clear EXE_valid, clear every buffer field to 0 and force the divider to IDLE, aborting any division in progress; after reset, EXE_allowin=1, EXE_to_MEM_valid=0, data_sram_en=0, data_sram_we=0 and EXE_rf_we_out=0.

Configuration
REQ-039 SHALL provide macro EXE_DIV_EN: when it is defined, the divider and REQ-033 to REQ-037 are present; when it is undefined, ops C-F return 0, ready_go is constantly 1, and no divider state exists.

Verification
REQ-040 SHALL cover ADD with src1=5 and src2=7, MEM_allowin=1: EXE_to_MEM_valid is 1 the cycle after capture, alu_res is 12, and data_sram_en is 0.
REQ-041 SHALL cover byte store to address 0x1003 with st=0xAB: data_sram_we is 4'b1000, wdata is 0xABABABAB, and en is 1 for exactly one cycle.
REQ-042 SHALL cover DIV of -7 by 2: after 33 cycles the result is 0xFFFFFFFD; MOD of the same operands gives 0xFFFFFFFF; EXE_allowin is 0 throughout the division.
REQ-043 SHALL cover DIVU of 9 by 0: the result is 0xFFFFFFFF; with MEM_allowin held 0 for 5 cycles, the result and valid remain stable.
REQ-044 SHALL cover resetn=0 asserted at cycle 10 of a division: EXE_valid is 0 the next cycle, and a subsequent ADD completes normally.
